// File: rtl/gray_binarize_pkg.sv
// Shared definitions for the gray binarization stage: image geometry,
// FSM encodings, output pixel levels and the default threshold.
package gray_binarize_pkg;

  localparam int unsigned BYTE_WIDTH  = 8;
  localparam int unsigned ADDR_WIDTH  = 20;
  localparam int unsigned HEADER_SIZE = 54;
  localparam int unsigned NUM_PIXELS  = 262144;
  localparam int unsigned TOTAL_SIZE  = HEADER_SIZE + 3 * NUM_PIXELS;
  localparam int unsigned THRESHOLD   = 128;

  localparam logic [7:0] BIN_WHITE = 8'hFF;
  localparam logic [7:0] BIN_BLACK = 8'h00;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_SUM  = 3'd1;
  localparam logic [2:0] ST_DIV  = 3'd2;
  localparam logic [2:0] ST_COPY = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

endpackage

// File: rtl/gray_binarize_if.sv
// Source (gray) RAM read port and destination (binary) RAM write port.
interface gray_binarize_if #(
  parameter int unsigned BYTE_WIDTH = gray_binarize_pkg::BYTE_WIDTH,
  parameter int unsigned ADDR_WIDTH = gray_binarize_pkg::ADDR_WIDTH
);
  logic                  src_ren;
  logic [ADDR_WIDTH-1:0] src_addr;
  logic [BYTE_WIDTH-1:0] src_data;
  logic                  dst_wen;
  logic [ADDR_WIDTH-1:0] dst_addr;
  logic [BYTE_WIDTH-1:0] dst_data;

  modport master (
    output src_ren, src_addr, dst_wen, dst_addr, dst_data,
    input  src_data
  );

  modport slave (
    input  src_ren, src_addr, dst_wen, dst_addr, dst_data,
    output src_data
  );
endinterface

// File: rtl/gray_binarize_seq_udiv.sv
// Restoring serial unsigned divider: one quotient bit per cycle after start,
// o_done pulses for one cycle when o_quotient is final.
module seq_udiv #(
  parameter int unsigned DVD_W = 26,
  parameter int unsigned DVS_W = 19
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [DVD_W-1:0] i_dividend,
  input  logic [DVS_W-1:0] i_divisor,
  output logic             o_busy,
  output logic             o_done,
  output logic [DVD_W-1:0] o_quotient
);
  import gray_binarize_pkg::*;

  localparam int unsigned CNT_W = $clog2(DVD_W + 1);

  logic [DVS_W-1:0] r_rem;
  logic [DVD_W-1:0] r_quot;
  logic [DVS_W-1:0] r_dvs;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [DVS_W:0]   w_rem_sh;
  logic             w_ge;

  // Dividend bits shift out of the quotient register into the remainder.
  assign w_rem_sh = {r_rem, r_quot[DVD_W-1]};
  assign w_ge     = (w_rem_sh >= {1'b0, r_dvs});

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rem  <= '0;
      r_quot <= '0;
      r_dvs  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start && !r_busy) begin
        r_rem  <= '0;
        r_quot <= i_dividend;
        r_dvs  <= i_divisor;
        r_cnt  <= CNT_W'(DVD_W);
        r_busy <= 1'b1;
      end else if (r_busy) begin
        r_rem  <= DVS_W'(w_ge ? (w_rem_sh - {1'b0, r_dvs}) : w_rem_sh);
        r_quot <= {r_quot[DVD_W-2:0], w_ge};
        r_cnt  <= r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_quotient = r_quot;
endmodule

// File: rtl/gray_binarize.sv
// Thresholds a gray BMP into black/white, copying the header verbatim.
// Define MEAN_THRESH_EN to use the image mean as threshold (two-pass flow).
module gray_binarize #(
  parameter int unsigned BYTE_WIDTH  = gray_binarize_pkg::BYTE_WIDTH,
  parameter int unsigned ADDR_WIDTH  = gray_binarize_pkg::ADDR_WIDTH,
  parameter int unsigned HEADER_SIZE = gray_binarize_pkg::HEADER_SIZE,
  parameter int unsigned NUM_PIXELS  = gray_binarize_pkg::NUM_PIXELS,
  parameter int unsigned TOTAL_SIZE  = gray_binarize_pkg::TOTAL_SIZE,
  parameter int unsigned THRESHOLD   = gray_binarize_pkg::THRESHOLD
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  gray_binarize_if.master       bus,
  output logic [BYTE_WIDTH-1:0] o_thresh_out,
  output logic                  o_bin_done
);
  import gray_binarize_pkg::*;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(TOTAL_SIZE - 1);
  localparam logic [ADDR_WIDTH-1:0] HDR_ADDR  = ADDR_WIDTH'(HEADER_SIZE);

  logic [2:0]            r_state, w_state_nxt;
  logic                  r_src_ren, w_src_ren_nxt;
  logic [ADDR_WIDTH-1:0] r_src_addr, w_src_addr_nxt;
  logic                  r_dst_wen;
  logic [ADDR_WIDTH-1:0] r_dst_addr;
  logic [1:0]            r_ch;
  logic                  r_dec;
  logic                  r_done;
  logic [BYTE_WIDTH-1:0] r_thresh;
  logic [BYTE_WIDTH-1:0] w_dst_data;
  logic                  w_hdr;
  logic                  w_white;
  logic                  w_copy_rd;

`ifdef MEAN_THRESH_EN
  localparam int unsigned ACC_W = BYTE_WIDTH + $clog2(NUM_PIXELS);
  localparam int unsigned DVS_W = $clog2(NUM_PIXELS + 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_PIX = ADDR_WIDTH'(HEADER_SIZE + 3 * (NUM_PIXELS - 1));

  logic [ACC_W-1:0] r_acc;
  logic             r_acc_vld;
  logic             r_div_start;
  logic             w_div_start;
  logic             w_div_busy;
  logic             w_div_done;
  logic [ACC_W-1:0] w_quot;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_src_ren_nxt  = r_src_ren;
    w_src_addr_nxt = r_src_addr;
`ifdef MEAN_THRESH_EN
    w_div_start    = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_src_ren_nxt = 1'b1;
`ifdef MEAN_THRESH_EN
          w_state_nxt    = ST_SUM;
          w_src_addr_nxt = HDR_ADDR;
`else
          w_state_nxt    = ST_COPY;
          w_src_addr_nxt = '0;
`endif
        end
      end
`ifdef MEAN_THRESH_EN
      // Channel-0 reads, then one drain cycle for the last accumulate.
      ST_SUM: begin
        if (r_src_ren) begin
          if (r_src_addr == LAST_PIX) w_src_ren_nxt  = 1'b0;
          else                        w_src_addr_nxt = r_src_addr + ADDR_WIDTH'(3);
        end else if (!w_div_busy) begin
          w_state_nxt = ST_DIV;
          w_div_start = 1'b1;
        end
      end
      ST_DIV: begin
        if (w_div_done) begin
          w_state_nxt    = ST_COPY;
          w_src_ren_nxt  = 1'b1;
          w_src_addr_nxt = '0;
        end
      end
`endif
      ST_COPY: begin
        if (r_src_ren) begin
          if (r_src_addr == LAST_ADDR) w_src_ren_nxt  = 1'b0;
          else                         w_src_addr_nxt = r_src_addr + ADDR_WIDTH'(1);
        end
        if (r_dst_wen && (r_dst_addr == LAST_ADDR)) w_state_nxt = ST_DONE;
      end
      ST_DONE: ;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_copy_rd = (r_state == ST_COPY) && r_src_ren;
  assign w_hdr     = (r_dst_addr < HDR_ADDR);
  assign w_white   = (bus.src_data >= r_thresh);

  // Read data arrives in the write cycle, so the write byte is formed from it directly.
  always_comb begin
    w_dst_data = '0;
    if (r_dst_wen) begin
      if (w_hdr)              w_dst_data = bus.src_data;
      else if (r_ch == 2'd0)  w_dst_data = w_white ? BYTE_WIDTH'(BIN_WHITE) : BYTE_WIDTH'(BIN_BLACK);
      else                    w_dst_data = r_dec ? BYTE_WIDTH'(BIN_WHITE) : BYTE_WIDTH'(BIN_BLACK);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_src_ren  <= 1'b0;
      r_src_addr <= '0;
      r_dst_wen  <= 1'b0;
      r_dst_addr <= '0;
      r_ch       <= 2'd0;
      r_dec      <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_src_ren  <= w_src_ren_nxt;
      r_src_addr <= w_src_addr_nxt;
      r_dst_wen  <= w_copy_rd;
      if (w_copy_rd) r_dst_addr <= r_src_addr;
      // Channel 0 decides; channels 1 and 2 replay the latched decision.
      if (r_dst_wen && !w_hdr) begin
        r_ch <= (r_ch == 2'd2) ? 2'd0 : r_ch + 2'd1;
        if (r_ch == 2'd0) r_dec <= w_white;
      end
      r_done <= (w_state_nxt == ST_DONE);
    end
  end

`ifdef MEAN_THRESH_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_acc       <= '0;
      r_acc_vld   <= 1'b0;
      r_div_start <= 1'b0;
      r_thresh    <= '0;
    end else begin
      r_acc_vld   <= (r_state == ST_SUM) && r_src_ren;
      r_div_start <= w_div_start;
      if (r_state == ST_IDLE) r_acc <= '0;
      else if (r_acc_vld)     r_acc <= r_acc + ACC_W'(bus.src_data);
      // The mean never exceeds a byte; saturate rather than wrap regardless.
      if (w_div_done)
        r_thresh <= (|w_quot[ACC_W-1:BYTE_WIDTH]) ? '1 : w_quot[BYTE_WIDTH-1:0];
    end
  end

  seq_udiv #(
    .DVD_W (ACC_W),
    .DVS_W (DVS_W)
  ) u_div (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_start    (r_div_start),
    .i_dividend (r_acc),
    .i_divisor  (DVS_W'(NUM_PIXELS)),
    .o_busy     (w_div_busy),
    .o_done     (w_div_done),
    .o_quotient (w_quot)
  );
`else
  assign r_thresh = BYTE_WIDTH'(THRESHOLD);
`endif

  assign bus.src_ren   = r_src_ren;
  assign bus.src_addr  = r_src_addr;
  assign bus.dst_wen   = r_dst_wen;
  assign bus.dst_addr  = r_dst_addr;
  assign bus.dst_data  = w_dst_data;
  assign o_thresh_out  = r_thresh;
  assign o_bin_done    = r_done;
endmodule

// File: tb/tb_gray_binarize.sv
// Directed bench for gray_binarize on a 4-byte header, 4-pixel image.
module tb_gray_binarize;

  localparam int unsigned HS = 4;
  localparam int unsigned NP = 4;
  localparam int unsigned TS = 16;

`ifdef MEAN_THRESH_EN
  localparam logic [7:0] RST_THR = 8'd0;
`else
  localparam logic [7:0] RST_THR = 8'd128;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] thresh;
  logic       done;

  always #5 clk = ~clk;

  gray_binarize_if #(.BYTE_WIDTH(8), .ADDR_WIDTH(20)) bus ();

  gray_binarize #(
    .HEADER_SIZE (HS),
    .NUM_PIXELS  (NP),
    .TOTAL_SIZE  (TS)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start),
    .bus          (bus),
    .o_thresh_out (thresh),
    .o_bin_done   (done)
  );

  logic [7:0]  src_mem [TS];
  logic [7:0]  dst_mem [TS];
  logic [31:0] hdr = {8'd11, 8'd22, 8'd33, 8'd44};
  int          wr_cnt;
  int          vectors = 0;
  int          miscompares = 0;

  // RAM models: one-cycle read latency; write side cleared by reset.
  always @(posedge clk) begin
    if (bus.src_ren) bus.src_data <= src_mem[bus.src_addr[3:0]];
    if (rst) begin
      wr_cnt <= 0;
      for (int i = 0; i < TS; i++) dst_mem[i] <= 8'h5A;
    end else if (bus.dst_wen) begin
      if (bus.dst_addr < 20'(TS)) dst_mem[bus.dst_addr[3:0]] <= bus.dst_data;
      wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply_reset();
    rst   = 1'b1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Grays packed MSB-first; junk puts non-gray values in channels 1 and 2.
  task automatic load_image(input logic [31:0] g, input bit junk);
    for (int i = 0; i < HS; i++) src_mem[i] = hdr[31-8*i -: 8];
    for (int p = 0; p < NP; p++) begin
      src_mem[HS+3*p]   = g[31-8*p -: 8];
      src_mem[HS+3*p+1] = junk ? ~g[31-8*p -: 8] : g[31-8*p -: 8];
      src_mem[HS+3*p+2] = junk ? 8'h80 : g[31-8*p -: 8];
    end
  endtask

  task automatic check_image(input string tag, input logic [31:0] e);
    for (int i = 0; i < HS; i++)
      chk($sformatf("%s hdr[%0d]", tag, i), 32'(dst_mem[i]), 32'(hdr[31-8*i -: 8]));
    for (int p = 0; p < NP; p++)
      for (int c = 0; c < 3; c++)
        chk($sformatf("%s pix[%0d]", tag, HS+3*p+c), 32'(dst_mem[HS+3*p+c]), 32'(e[31-8*p -: 8]));
  endtask

  // Runs until bin_done; lat = cycles from first COPY read to bin_done.
  task automatic run_wait(input bit hold, input bit toggle, output int lat);
    int entry;
    entry = -1;
    lat   = -1;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      else if (toggle && bus.dst_wen && bus.dst_addr >= 20'd5 && bus.dst_addr <= 20'd8) start = ~start;
      else start = 1'b1;
      if (entry < 0 && bus.src_ren && bus.src_addr == 20'd0) entry = c;
      if (done) begin
        if (entry >= 0) lat = c - entry;
        break;
      end
    end
    chk("bin_done reached", 32'(done), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " src_ren"},  32'(bus.src_ren),  32'd0);
    chk({tag, " src_addr"}, 32'(bus.src_addr), 32'd0);
    chk({tag, " dst_wen"},  32'(bus.dst_wen),  32'd0);
    chk({tag, " dst_addr"}, 32'(bus.dst_addr), 32'd0);
    chk({tag, " dst_data"}, 32'(bus.dst_data), 32'd0);
    chk({tag, " bin_done"}, 32'(done),         32'd0);
    chk({tag, " thresh"},   32'(thresh),       32'(RST_THR));
  endtask

  logic [31:0] exp_a;
  logic [7:0]  thr_a;
  int          lat;
  bit          hit;

  initial begin
`ifdef MEAN_THRESH_EN
    exp_a = 32'hFFFF00FF;
    thr_a = 8'd127;
`else
    exp_a = 32'h00FF00FF;
    thr_a = 8'd128;
`endif
    rst   = 1'b1;
    start = 1'b0;

    // Reset state
    apply_reset();
    check_reset_outputs("reset");

    // Grays 127,128,0,255
    load_image({8'd127, 8'd128, 8'd0, 8'd255}, 1'b0);
    start = 1'b1;
    run_wait(1'b0, 1'b0, lat);
    chk("copy->done latency", 32'(lat), 32'd17);
    chk("thresh run1", 32'(thresh), 32'(thr_a));
    chk("writes run1", 32'(wr_cnt), 32'd16);
    check_image("run1", exp_a);

    // Reset mid-COPY at dst_addr 7
    apply_reset();
    start = 1'b1;
    hit   = 1'b0;
    for (int c = 0; c < 300 && !hit; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (bus.dst_wen && bus.dst_addr == 20'd7) hit = 1'b1;
    end
    chk("reached dst_addr 7", 32'(hit), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs("mid-rst");
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("no writes after rst", 32'(wr_cnt), 32'd0);
    chk("idle after rst", 32'(done), 32'd0);
    start = 1'b1;
    run_wait(1'b0, 1'b0, lat);
    chk("writes restart", 32'(wr_cnt), 32'd16);
    check_image("restart", exp_a);

    // start held through DONE, toggled during COPY; junk in channels 1/2
    apply_reset();
    load_image({8'd127, 8'd128, 8'd0, 8'd255}, 1'b1);
    start = 1'b1;
    run_wait(1'b1, 1'b1, lat);
    repeat (30) @(negedge clk);
    chk("writes held start", 32'(wr_cnt), 32'd16);
    chk("done stays", 32'(done), 32'd1);
    chk("no read in DONE", 32'(bus.src_ren), 32'd0);
    check_image("held", exp_a);

`ifdef MEAN_THRESH_EN
    // Mean 25
    apply_reset();
    load_image({8'd10, 8'd20, 8'd30, 8'd40}, 1'b0);
    start = 1'b1;
    run_wait(1'b0, 1'b0, lat);
    chk("thresh mean25", 32'(thresh), 32'd25);
    chk("latency mean25", 32'(lat), 32'd17);
    check_image("mean25", 32'h0000FFFF);

    // All 255: equality is white
    apply_reset();
    load_image({8'd255, 8'd255, 8'd255, 8'd255}, 1'b0);
    start = 1'b1;
    run_wait(1'b0, 1'b0, lat);
    chk("thresh all255", 32'(thresh), 32'd255);
    check_image("all255", 32'hFFFFFFFF);

    // All 0
    apply_reset();
    load_image(32'h00000000, 1'b0);
    start = 1'b1;
    run_wait(1'b0, 1'b0, lat);
    chk("thresh all0", 32'(thresh), 32'd0);
    chk("writes all0", 32'(wr_cnt), 32'd16);
    check_image("all0", 32'hFFFFFFFF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
